// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of multiplier products into dot-product results
// and hands finished sums to the consumer through a 2-entry valid/ready result queue.
module product_accumulator #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned LEN       = 8,
    localparam int unsigned CW       = $clog2(LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [2*WIDTH-1:0]     in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic                   out_ovf,
    output logic [CW-1:0]          out_count,
    output logic                   overrun
);

    localparam int unsigned SW = ACC_WIDTH + 1;

    typedef struct packed {
        logic [ACC_WIDTH-1:0] data;
        logic                 ovf;
        logic [CW-1:0]        count;
    } result_t;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 grp_ovf_q, grp_ovf_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    result_t              slot0_q, slot0_d;
    result_t              slot1_q, slot1_d;
    logic                 v0_q, v0_d;
    logic                 v1_q, v1_d;
    logic                 overrun_q, overrun_d;

    logic [ACC_WIDTH-1:0] base;
    logic [SW-1:0]        sum_ext;
    logic                 ovf_n;
    logic                 push;
    logic                 pop;
    result_t              push_res;

    // Next-state logic: group accumulation plus the two-slot result queue.
    always_comb begin
        acc_d     = acc_q;
        grp_ovf_d = grp_ovf_q;
        cnt_d     = cnt_q;
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        overrun_d = overrun_q;

        // A new group starts from zero, so the stale accumulator is ignored when cnt is 0.
        base    = (cnt_q == '0) ? '0 : acc_q;
        sum_ext = SW'(base) + SW'(in_data);
        ovf_n   = ((cnt_q != '0) && grp_ovf_q) || sum_ext[ACC_WIDTH];
        push    = in_valid && (in_last || (cnt_q == CW'(LEN - 1)));
        pop     = v0_q && out_ready;

        push_res.data  = sum_ext[ACC_WIDTH-1:0];
        push_res.ovf   = ovf_n;
        push_res.count = cnt_q + CW'(1);

        if (in_valid) begin
            if (push) begin
                acc_d     = '0;
                grp_ovf_d = 1'b0;
                cnt_d     = '0;
            end else begin
                acc_d     = sum_ext[ACC_WIDTH-1:0];
                grp_ovf_d = ovf_n;
                cnt_d     = cnt_q + CW'(1);
            end
        end

        // Empty slots are kept at zero so the head outputs read 0 when nothing is queued.
        case ({push, pop})
            2'b11: begin
                if (v1_q) begin
                    slot0_d = slot1_q;
                    slot1_d = push_res;
                end else begin
                    slot0_d = push_res;
                end
            end
            2'b10: begin
                if (!v0_q) begin
                    slot0_d = push_res;
                    v0_d    = 1'b1;
                end else if (!v1_q) begin
                    slot1_d = push_res;
                    v1_d    = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end
            2'b01: begin
                if (v1_q) begin
                    slot0_d = slot1_q;
                    slot1_d = '0;
                    v1_d    = 1'b0;
                end else begin
                    slot0_d = '0;
                    v0_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= '0;
            grp_ovf_q <= 1'b0;
            cnt_q     <= '0;
            slot0_q   <= '0;
            slot1_q   <= '0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            grp_ovf_q <= grp_ovf_d;
            cnt_q     <= cnt_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_valid = v0_q;
    assign out_data  = slot0_q.data;
    assign out_ovf   = slot0_q.ovf;
    assign out_count = slot0_q.count;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed scenarios plus random traffic against a queue-based reference model.
module tb_product_accumulator;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned ACC_WIDTH = 32;
    localparam int unsigned LEN       = 4;
    localparam int unsigned CW        = $clog2(LEN + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic [2*WIDTH-1:0]   in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic                 out_ovf;
    logic [CW-1:0]        out_count;
    logic                 overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: true (unbounded) running sum, and a queue of finished results.
    longint unsigned m_sum;
    int              m_cnt;
    bit              m_overrun;
    longint unsigned q_data[$];
    bit              q_ovf[$];
    int              q_cnt[$];

    product_accumulator #(
        .WIDTH    (WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .LEN      (LEN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .out_count(out_count),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit rst, input bit v, input bit l, input longint unsigned d,
                                input bit r);
        if (rst) begin
            m_sum = 0;
            m_cnt = 0;
            m_overrun = 1'b0;
            q_data.delete();
            q_ovf.delete();
            q_cnt.delete();
        end else begin
            if (r && q_data.size() > 0) begin
                void'(q_data.pop_front());
                void'(q_ovf.pop_front());
                void'(q_cnt.pop_front());
            end
            if (v) begin
                m_sum += d;
                m_cnt++;
                if (l || m_cnt == int'(LEN)) begin
                    if (q_data.size() < 2) begin
                        q_data.push_back(m_sum % (64'd1 << ACC_WIDTH));
                        q_ovf.push_back(m_sum >= (64'd1 << ACC_WIDTH));
                        q_cnt.push_back(m_cnt);
                    end else begin
                        m_overrun = 1'b1;
                    end
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        bit has = (q_data.size() > 0);
        check("out_valid", 64'(out_valid), 64'(has));
        check("out_data",  64'(out_data),  has ? q_data[0] : 64'd0);
        check("out_ovf",   64'(out_ovf),   has ? 64'(q_ovf[0]) : 64'd0);
        check("out_count", 64'(out_count), has ? 64'(q_cnt[0]) : 64'd0);
        check("overrun",   64'(overrun),   64'(m_overrun));
    endtask

    // One clock: drive inputs, let the edge happen, update the model, check at the falling edge.
    task automatic step(input bit rst, input bit v, input bit l, input logic [31:0] d, input bit r);
        rst_n     = ~rst;
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        model_update(rst, v, l, 64'(d), r);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        m_sum = 0;
        m_cnt = 0;
        m_overrun = 1'b0;

        // Reset state.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        check("rst_valid", 64'(out_valid), 0);
        check("rst_overrun", 64'(overrun), 0);

        // Full-length group of 3,5,7,11.
        step(0, 1, 0, 3, 1);
        step(0, 1, 0, 5, 1);
        step(0, 1, 0, 7, 1);
        step(0, 1, 0, 11, 1);
        check("t1_data", 64'(out_data), 26);
        check("t1_count", 64'(out_count), 4);
        check("t1_ovf", 64'(out_ovf), 0);
        step(0, 0, 0, 0, 1);
        check("t1_one_cycle", 64'(out_valid), 0);

        // Early close with in_last, then a full group.
        step(0, 1, 0, 100, 1);
        step(0, 1, 1, 200, 1);
        check("t2_a_data", 64'(out_data), 300);
        check("t2_a_count", 64'(out_count), 2);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 1);
        check("t2_b_data", 64'(out_data), 4);
        check("t2_b_count", 64'(out_count), 4);
        step(0, 0, 1, 0, 1);

        // Single-product groups into a stalled queue: third result is dropped.
        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 2, 0);
        step(0, 1, 1, 3, 0);
        check("t3_overrun", 64'(overrun), 1);
        check("t3_head", 64'(out_data), 1);
        step(0, 0, 0, 0, 1);
        check("t3_second", 64'(out_data), 2);
        step(0, 0, 0, 0, 1);
        check("t3_empty", 64'(out_valid), 0);
        check("t3_sticky", 64'(overrun), 1);

        // Full queue with simultaneous push and pop.
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 7, 0);
        step(0, 1, 1, 8, 0);
        step(0, 1, 1, 9, 1);
        check("t4_no_overrun", 64'(overrun), 0);
        check("t4_head", 64'(out_data), 8);
        step(0, 0, 0, 0, 1);
        check("t4_next", 64'(out_data), 9);
        step(0, 0, 0, 0, 1);

        // Wrap past 2^32.
        step(0, 1, 0, 32'hFFFF_FFFE, 1);
        step(0, 1, 1, 32'h3, 1);
        check("t5_data", 64'(out_data), 1);
        check("t5_ovf", 64'(out_ovf), 1);
        step(0, 1, 1, 32'h5, 1);
        check("t5_next_ovf", 64'(out_ovf), 0);
        step(0, 0, 0, 0, 1);

        // Reset in mid-group discards the partial sum.
        step(0, 1, 0, 50, 1);
        step(0, 1, 0, 60, 1);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 1);
        check("t6_data", 64'(out_data), 4);
        check("t6_count", 64'(out_count), 4);
        check("t6_overrun", 64'(overrun), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          rst = ($urandom_range(0, 99) < 2);
            bit          v   = ($urandom_range(0, 9) < 7);
            bit          l   = ($urandom_range(0, 9) < 2);
            logic [31:0] d   = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 65535));
            bit          r   = ($urandom_range(0, 1) == 1);
            step(rst, v, l, d, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
